// File: rtl/cfi_pkg.sv
// rtl/cfi_pkg.sv - shared CFI log record type and mailbox constants
package cfi_pkg;

  localparam int CFI_LOG_W = 256;
  typedef logic [CFI_LOG_W-1:0] cfi_log_t;

  localparam int CFI_MBOX_BEAT_W     = 32;
  localparam int CFI_MBOX_BEATS      = 8;
  localparam int CFI_MBOX_BEAT_CNT_W = $clog2(CFI_MBOX_BEATS);
  localparam logic [CFI_MBOX_BEAT_W-1:0] CFI_MBOX_BELL_VAL = 32'h1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA_AW = 3'd1;
  localparam logic [2:0] ST_DATA_W  = 3'd2;
  localparam logic [2:0] ST_DATA_B  = 3'd3;
  localparam logic [2:0] ST_BELL_AW = 3'd4;
  localparam logic [2:0] ST_BELL_W  = 3'd5;
  localparam logic [2:0] ST_BELL_B  = 3'd6;

  function automatic logic is_b_state(logic [2:0] s);
    return (s == ST_DATA_B) || (s == ST_BELL_B);
  endfunction

endpackage

// File: rtl/cfi_rr_arbiter.sv
// rtl/cfi_rr_arbiter.sv - round-robin pick starting one past the last granted index
module cfi_rr_arbiter #(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] last_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      valid_o
);

  localparam int IdxW = $clog2(NumReq);

  always_comb begin
    logic [IdxW-1:0] cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 1; off <= NumReq; off++) begin
      cand = IdxW'((int'(last_i) + off) % NumReq);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/cfi_mbox_arbiter.sv
// rtl/cfi_mbox_arbiter.sv - shares one AXI mailbox among CFI log queues (data burst + doorbell)
// Optional B-response watchdog: CFI_MBOX_TIMEOUT_EN
module cfi_mbox_arbiter
  import cfi_pkg::*;
#(
  parameter int          NumReq        = 2,
  parameter logic [63:0] MboxBase      = 64'h0000_0000_1040_4000,
  parameter logic [63:0] BellOffset    = 64'h20,
  parameter int          TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  input  cfi_log_t [NumReq-1:0]     req_data_i,
  output logic [NumReq-1:0]         req_pop_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [63:0]               aw_addr_o,
  output logic [7:0]                aw_len_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [31:0]               w_data_o,
  output logic                      w_last_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] grant_o,
  output logic                      err_o,
  output logic                      timeout_o
);

  localparam int IdxW = $clog2(NumReq);

  logic [2:0]                     state_q, state_d;
  logic [CFI_MBOX_BEAT_CNT_W-1:0] beat_q, beat_d;
  cfi_log_t                       data_q, data_d;
  logic [IdxW-1:0]                grant_q, grant_d;
  logic [IdxW-1:0]                ptr_q, ptr_d;
  logic                           pop, err, tmo, tmo_hit;

  logic [NumReq-1:0] rr_gnt;
  logic [IdxW-1:0]   rr_idx;
  logic              rr_valid;
  cfi_log_t          rr_data;

  cfi_rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req_i   (req_valid_i),
    .last_i  (ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  always_comb begin
    rr_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (rr_gnt[i]) rr_data = rr_data | req_data_i[i];
    end
  end

`ifdef CFI_MBOX_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles) + 1;
  logic [TmoW-1:0] tmo_q;

  // Restarts whenever a B state is entered or left, so each wait is timed from its first cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (is_b_state(state_q) && (state_d == state_q)) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit = is_b_state(state_q) && !b_valid_i && (tmo_q == TmoW'(TimeoutCycles - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    pop     = 1'b0;
    err     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          grant_d = rr_idx;
          ptr_d   = rr_idx;
          data_d  = rr_data;
          beat_d  = '0;
          state_d = ST_DATA_AW;
        end
      end
      ST_DATA_AW: if (aw_ready_i) state_d = ST_DATA_W;
      ST_DATA_W: begin
        if (w_ready_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == CFI_MBOX_BEAT_CNT_W'(CFI_MBOX_BEATS - 1)) state_d = ST_DATA_B;
        end
      end
      ST_DATA_B: begin
        if (b_valid_i) begin
          // A failed data write makes the doorbell meaningless; drop the entry instead.
          if (b_resp_i != 2'b00) begin
            err     = 1'b1;
            pop     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BELL_AW;
          end
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BELL_AW: if (aw_ready_i) state_d = ST_BELL_W;
      ST_BELL_W:  if (w_ready_i) state_d = ST_BELL_B;
      ST_BELL_B: begin
        if (b_valid_i) begin
          err     = (b_resp_i != 2'b00);
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= IdxW'(NumReq - 1);
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  logic [CFI_MBOX_BEATS-1:0][CFI_MBOX_BEAT_W-1:0] beats;
  assign beats = data_q;

  assign busy_o     = (state_q != ST_IDLE);
  assign grant_o    = grant_q;
  assign aw_valid_o = (state_q == ST_DATA_AW) || (state_q == ST_BELL_AW);
  assign aw_addr_o  = (state_q == ST_DATA_AW) ? MboxBase :
                      (state_q == ST_BELL_AW) ? MboxBase + BellOffset : '0;
  assign aw_len_o   = (state_q == ST_DATA_AW) ? 8'(CFI_MBOX_BEATS - 1) : 8'd0;
  assign w_valid_o  = (state_q == ST_DATA_W) || (state_q == ST_BELL_W);
  assign w_data_o   = (state_q == ST_DATA_W) ? beats[beat_q] :
                      (state_q == ST_BELL_W) ? CFI_MBOX_BELL_VAL : '0;
  assign w_last_o   = ((state_q == ST_DATA_W) && (beat_q == CFI_MBOX_BEAT_CNT_W'(CFI_MBOX_BEATS - 1))) ||
                      (state_q == ST_BELL_W);
  assign b_ready_o  = is_b_state(state_q);
  assign err_o      = err;
  assign timeout_o  = tmo;

  always_comb begin
    req_pop_o = '0;
    if (pop) req_pop_o[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_cfi_mbox_arbiter.sv
// tb/tb_cfi_mbox_arbiter.sv - vector table plus event scoreboard for cfi_mbox_arbiter
module tb_cfi_mbox_arbiter;
  import cfi_pkg::*;

  localparam int NumReq = 2;
  localparam int Tmo    = 16;
  localparam logic [63:0] MBOX = 64'h0000_0000_1040_4000;
  localparam logic [63:0] BELL = 64'h0000_0000_1040_4020;
  localparam int K_AW = 0, K_W = 1, K_POP = 2, K_ERR = 3, K_TMO = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0][255:0] req_data_i;
  logic [NumReq-1:0] req_pop_o;
  logic aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o;
  logic b_valid_i, b_ready_o, busy_o, err_o, timeout_o;
  logic [63:0] aw_addr_o;
  logic [7:0] aw_len_o;
  logic [31:0] w_data_o;
  logic [1:0] b_resp_i;
  logic [$clog2(NumReq)-1:0] grant_o;

  always #5 clk_i = ~clk_i;

  cfi_mbox_arbiter #(.NumReq(NumReq), .TimeoutCycles(Tmo)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_pop_o(req_pop_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .busy_o(busy_o), .grant_o(grant_o), .err_o(err_o), .timeout_o(timeout_o)
  );

  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [31:0] b;
    int          c;
  } ev_t;

  typedef struct {
    logic [1:0] valid;
    bit         toggle;
    logic [1:0] rd;
    logic [1:0] rb;
    int         exp_grant;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   w_hs_cnt = 0;
  int   bcycles = 0;
  bit   last_aw_bell = 1'b0;
  bit   w_toggle = 1'b0;
  bit   b_hold = 1'b0;
  logic [1:0] resp_data = 2'b00;
  logic [1:0] resp_bell = 2'b00;
  logic pw_valid = 1'b0, pw_hs = 1'b0, pw_last = 1'b0;
  logic [31:0] pw_data = '0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_val(int vi, int r, int k);
    return {8'(vi), 8'(r), 8'h00, 8'(k)};
  endfunction

  task automatic push(int kind, logic [63:0] a, logic [31:0] b, int c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_txn(int g, int vi, logic [1:0] rd, logic [1:0] rb, bit tmo);
    push(K_AW, MBOX, 32'd7, g);
    for (int k = 0; k < 8; k++) push(K_W, 64'(beat_val(vi, g, k)), 32'(k == 7), 0);
    if (tmo) push(K_TMO, 64'd0, 32'd0, 0);
    else if (rd != 2'b00) push(K_ERR, 64'd0, 32'd0, 0);
    else begin
      push(K_AW, BELL, 32'd0, g);
      push(K_W, 64'h1, 32'd1, 0);
      if (rb != 2'b00) push(K_ERR, 64'd0, 32'd0, 0);
    end
    push(K_POP, 64'(1 << g), 32'd0, 0);
  endtask

  task automatic set_data(int vi);
    for (int r = 0; r < NumReq; r++)
      for (int k = 0; k < 8; k++) req_data_i[r][32*k +: 32] = beat_val(vi, r, k);
  endtask

  task automatic observe(int kind, logic [63:0] a, logic [31:0] b, int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d a=%h b=%h c=%0d, expected none", kind, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b || e.c != c) begin
        errors++;
        $display("FAIL event: got kind=%0d a=%h b=%h c=%0d, expected kind=%0d a=%h b=%h c=%0d",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (b_ready_o) bcycles++; else bcycles = 0;
      if (aw_valid_o || w_valid_o) chk("aw_w_exclusive", 64'(aw_valid_o && w_valid_o), 64'd0);
      if (pw_valid && !pw_hs) begin
        chk("w_valid_held", 64'(w_valid_o), 64'd1);
        chk("w_payload_held", 64'({w_last_o, w_data_o}), 64'({pw_last, pw_data}));
      end
      if (aw_valid_o && aw_ready_i) begin
        observe(K_AW, aw_addr_o, 32'(aw_len_o), int'(grant_o));
        last_aw_bell = (aw_addr_o == BELL);
      end
      if (w_valid_o && w_ready_i) begin
        observe(K_W, 64'(w_data_o), 32'(w_last_o), 0);
        w_hs_cnt++;
      end
      if (timeout_o) begin
        observe(K_TMO, 64'd0, 32'd0, 0);
        chk("timeout_cycle", 64'(bcycles), 64'(Tmo));
      end
      if (err_o) observe(K_ERR, 64'd0, 32'd0, 0);
      if (req_pop_o != '0) observe(K_POP, 64'(req_pop_o), 32'd0, 0);
      pw_valid = w_valid_o;
      pw_hs    = w_valid_o && w_ready_i;
      pw_data  = w_data_o;
      pw_last  = w_last_o;
    end
  end

  initial begin : responder
    aw_ready_i = 1'b1;
    w_ready_i  = 1'b1;
    b_valid_i  = 1'b0;
    b_resp_i   = 2'b00;
    forever begin
      @(posedge clk_i);
      #1;
      w_ready_i = w_toggle ? ~w_ready_i : 1'b1;
      b_valid_i = b_ready_o && !b_hold;
      b_resp_i  = !b_valid_i ? 2'b00 : (last_aw_bell ? resp_bell : resp_data);
    end
  end

  task automatic wait_pop();
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk_i);
      if (req_pop_o != '0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL pop_wait: got no pop within 400 cycles, expected a pop");
    end
  endtask

  task automatic end_txn();
    @(posedge clk_i);
    #1;
    req_valid_i = '0;
    w_toggle    = 1'b0;
    resp_data   = 2'b00;
    resp_bell   = 2'b00;
    b_hold      = 1'b0;
    @(negedge clk_i);
    chk("idle_after_pop", 64'(busy_o), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_aw_valid", 64'(aw_valid_o), 64'd0);
    chk("rst_w_valid", 64'(w_valid_o), 64'd0);
    chk("rst_b_ready", 64'(b_ready_o), 64'd0);
    chk("rst_pop", 64'(req_pop_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_err_tmo", 64'({err_o, timeout_o}), 64'd0);
    chk("rst_aw_payload", aw_addr_o | 64'(aw_len_o), 64'd0);
    chk("rst_w_payload", 64'({w_last_o, w_data_o}), 64'd0);
  endtask

  initial begin : main
    int base;
    int n;
    req_valid_i = '0;
    req_data_i  = '0;
    vecs[0] = '{2'b01, 1'b0, 2'b00, 2'b00, 0};
    vecs[1] = '{2'b10, 1'b0, 2'b00, 2'b00, 1};
    vecs[2] = '{2'b11, 1'b0, 2'b00, 2'b00, 0};
    vecs[3] = '{2'b11, 1'b0, 2'b00, 2'b00, 1};
    vecs[4] = '{2'b01, 1'b1, 2'b00, 2'b00, 0};
    vecs[5] = '{2'b10, 1'b0, 2'b10, 2'b00, 1};
    vecs[6] = '{2'b01, 1'b0, 2'b00, 2'b01, 0};
    vecs[7] = '{2'b11, 1'b1, 2'b00, 2'b00, 1};

    repeat (3) @(negedge clk_i);
    chk_outputs_zero();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1;
      set_data(i);
      w_toggle  = vecs[i].toggle;
      resp_data = vecs[i].rd;
      resp_bell = vecs[i].rb;
      push_txn(vecs[i].exp_grant, i, vecs[i].rd, vecs[i].rb, 1'b0);
      req_valid_i = vecs[i].valid;
      wait_pop();
      end_txn();
    end

    // both requesters held valid: grants alternate with exactly one idle cycle between
    @(posedge clk_i);
    #1;
    set_data(9);
    for (int t = 0; t < 4; t++) push_txn(t % 2, 9, 2'b00, 2'b00, 1'b0);
    req_valid_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_pop();
      if (t < 3) begin
        @(negedge clk_i);
        chk("b2b_idle_cycle", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        chk("b2b_regrant", 64'(busy_o), 64'd1);
      end
    end
    end_txn();

    // reset while the beat counter sits at 4
    @(posedge clk_i);
    #1;
    set_data(10);
    base = w_hs_cnt;
    push(K_AW, MBOX, 32'd7, 0);
    for (int k = 0; k < 4; k++) push(K_W, 64'(beat_val(10, 0, k)), 32'd0, 0);
    req_valid_i = 2'b01;
    n = 0;
    while (w_hs_cnt < base + 4 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    chk("reach_beat4", 64'(n < 200), 64'd1);
    #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk_outputs_zero();
    chk("rst_partial_events", 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    chk("rst_no_pop", 64'(req_pop_o), 64'd0);
    push_txn(0, 10, 2'b00, 2'b00, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    wait_pop();
    end_txn();

    @(posedge clk_i);
    #1;
    set_data(11);
    b_hold = 1'b1;
`ifdef CFI_MBOX_TIMEOUT_EN
    push_txn(0, 11, 2'b00, 2'b00, 1'b1);
    req_valid_i = 2'b01;
    wait_pop();
    end_txn();
`else
    push_txn(0, 11, 2'b00, 2'b00, 1'b0);
    req_valid_i = 2'b01;
    n = 0;
    while (!b_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_data_b", 64'(b_ready_o), 64'd1);
    repeat (40) @(negedge clk_i);
    chk("no_tmo_busy", 64'(busy_o), 64'd1);
    chk("no_tmo_b_ready", 64'(b_ready_o), 64'd1);
    chk("no_tmo_pulse", 64'(timeout_o), 64'd0);
    b_hold = 1'b0;
    wait_pop();
    end_txn();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfi_mbox_arbiter.md
CFI_MBOX_ARBITER -- requirements
Module: cfi_mbox_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of log-queue requesters sharing the mailbox.
REQ-002 SHALL have parameter MboxBase, default 64'h0000_0000_1040_4000, mailbox data base address.
REQ-003 SHALL have parameter BellOffset, default 64'h20, doorbell register offset from MboxBase.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, B-response watchdog limit.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid_i in NumReq (queue non-empty), req_data_i in NumReq x 256 (cfi_log_t), req_pop_o out NumReq (1-cycle pop pulse).
REQ-008 SHALL have ports aw_valid_o out 1, aw_ready_i in 1, aw_addr_o out 64, aw_len_o out 8.
REQ-009 SHALL have ports w_valid_o out 1, w_ready_i in 1, w_data_o out 32, w_last_o out 1.
REQ-010 SHALL have ports b_valid_i in 1, b_ready_o out 1, b_resp_i in 2.
REQ-011 SHALL have ports busy_o out 1, grant_o out $clog2(NumReq), err_o out 1 (1-cycle pulse), timeout_o out 1 (1-cycle pulse).

Function
REQ-012 SHALL implement FSM IDLE, DATA_AW, DATA_W, DATA_B, BELL_AW, BELL_W, BELL_B.
- IDLE: any req_valid_i → register round-robin winner into grant_o, latch its req_data_i, go to DATA_AW.
- Round-robin: search starts at last granted index + 1, wrapping to 0 after NumReq-1.
REQ-013 SHALL, in DATA_AW, drive aw_addr_o=MboxBase and aw_len_o=7; on aw_valid_o&&aw_ready_i go to DATA_W.
REQ-014 SHALL, in DATA_W, send 8 beats with a 3-bit beat counter; beat k carries latched bits [32k+31:32k].
- Counter advances only on w_valid_o&&w_ready_i.
- w_last_o=1 on beat 7; handshake of beat 7 → DATA_B.
REQ-015 SHALL, in DATA_B, assert b_ready_o; on b_valid_i go to BELL_AW.
REQ-016 SHALL, in BELL_AW, drive aw_addr_o=MboxBase+BellOffset and aw_len_o=0.
- In BELL_W, send single beat w_data_o=32'h1 with w_last_o=1.
- In BELL_B, on b_valid_i: pulse req_pop_o[grant_o] and return to IDLE.
REQ-017 SHALL never assert aw_valid_o and w_valid_o in the same cycle.
- Once asserted, a valid SHALL hold with stable payload until its handshake.
REQ-018 SHALL pulse err_o on any b_resp_i != 2'b00 in DATA_B or BELL_B.
- Error in DATA_B: skip doorbell, pop the entry, return to IDLE.
- Error in BELL_B: pop the entry and return to IDLE.
REQ-019 SHALL keep busy_o=1 in every state except IDLE.
REQ-020 SHALL ignore req_valid_i changes while busy; a dropped non-granted request is never popped.
REQ-021 SHALL grant a single active requester on consecutive transactions without idle gaps beyond the one IDLE cycle.

Reset
REQ-022 SHALL, on rst_ni low (including mid-burst): state=IDLE, beat counter=0, round-robin pointer=NumReq-1, latched data=0.
- All outputs SHALL be 0.
- The interrupted entry SHALL not be popped.

Configuration
REQ-023 SHALL, with CFI_MBOX_TIMEOUT_EN defined, count cycles spent in DATA_B/BELL_B.
- Counter clears on entering either state.
- When the count reaches TimeoutCycles-1 with no b_valid_i: pulse timeout_o, pop the entry, return to IDLE.
REQ-024 SHALL, without CFI_MBOX_TIMEOUT_EN, contain no timeout counter, tie timeout_o to 0, and wait indefinitely in DATA_B/BELL_B.

Structure
REQ-025 SHALL take cfi_log_t, the mailbox beat width (32), and the beat count (8) from cfi_pkg.
- SHALL add the constants CFI_MBOX_BEATS and CFI_MBOX_BELL_VAL to cfi_pkg.
REQ-026 SHALL place the round-robin pick in sub-module cfi_rr_arbiter (req vector and last pointer in, one-hot grant plus index out).

Verification
REQ-027 SHALL cover single request, ready tied high:
- req_valid_i=01, data=256'h0..07_..._00 → AW addr 0x10404000 len 7, then 8 beats 0x0..0x7 with last on beat 7.
- Then AW 0x10404020 len 0, W 0x1.
- req_pop_o=01 exactly one cycle, 8 cycles after BELL_B entry-or-less.
REQ-028 SHALL cover both requesters continuously valid → grants alternate 0,1,0,1 over 4 transactions.
REQ-029 SHALL cover backpressure: w_ready_i toggles every cycle → beat data and w_valid_o held stable, exactly 8 data handshakes.
REQ-030 SHALL cover error response: b_resp_i=2'b10 in DATA_B → err_o pulse, no doorbell AW, pop pulse, IDLE.
REQ-031 SHALL cover timeout with CFI_MBOX_TIMEOUT_EN defined and TimeoutCycles=16: b_valid_i held 0 → timeout_o at cycle 16 of DATA_B, pop, IDLE.
REQ-032 SHALL cover reset mid-burst: rst_ni low at beat 4 → all outputs 0, no pop; after release the same request restarts at beat 0.
